// File: rtl/mem_fill_pkg.sv
// mem_fill_pkg: shared types and widths for the mem_fill RAM initialiser.
//   fill_mode_e : IDENTITY (d=i), CONST (d=fill_val), RAMP (d=fill_val+i*step); code 3 behaves as CONST
//   state_e     : IDLE -> FILL -> [VERIFY] -> DONE -> IDLE
//   MODE_W      : width of the mode field
package mem_fill_pkg;
    localparam int MODE_W = 2;
    typedef enum logic [MODE_W-1:0] {IDENTITY = 2'd0, CONST = 2'd1, RAMP = 2'd2} fill_mode_e;
    typedef enum logic [1:0] {IDLE, FILL, VERIFY, DONE} state_e;
endpackage

// File: rtl/mem_fill_if.sv
// mem_fill_if: controller handshake plus RAM port of mem_fill.
//   master : controller/RAM side (drives en, request fields, ram_dout)
//   slave  : mem_fill side (drives rdy, done, err, err_addr, ram_addr, ram_din, ram_wren)
interface mem_fill_if #(parameter int ADDR_W = 8, parameter int DATA_W = 8);
    import mem_fill_pkg::*;
    logic              rdy;
    logic              en;
    logic [MODE_W-1:0] mode;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   len;
    logic [DATA_W-1:0] fill_val;
    logic [DATA_W-1:0] step;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] err_addr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic              ram_wren;
    modport master (input rdy, done, err, err_addr, ram_addr, ram_din, ram_wren,
                    output en, mode, start_addr, len, fill_val, step, ram_dout);
    modport slave  (output rdy, done, err, err_addr, ram_addr, ram_din, ram_wren,
                    input en, mode, start_addr, len, fill_val, step, ram_dout);
endinterface

// File: rtl/mem_fill_datagen.sv
// mem_fill_datagen: address counter plus data accumulator producing word i of a fill sequence.
//   restart : load start/base/mode/step; addr/data then present word 0
//   advance : step to the next word (addr+1, data+1 / +step / +0 by mode)
//   addr, data : registered word address and data
module mem_fill_datagen
    import mem_fill_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              advance,
    input  logic [MODE_W-1:0] mode,
    input  logic [ADDR_W-1:0] start,
    input  logic [DATA_W-1:0] base,
    input  logic [DATA_W-1:0] step,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);
    logic [MODE_W-1:0] mode_q;
    logic [DATA_W-1:0] step_q;
    logic [DATA_W-1:0] inc;
    // identity data equals the index, so it advances by one; const never moves
    assign inc = mode_q == IDENTITY ? DATA_W'(1) : mode_q == RAMP ? step_q : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            addr   <= '0;
            data   <= '0;
            mode_q <= '0;
            step_q <= '0;
        end else if (restart) begin
            addr   <= start;
            data   <= mode == IDENTITY ? '0 : base;
            mode_q <= mode;
            step_q <= step;
        end else if (advance) begin
            addr <= addr + 1'b1;
            data <= data + inc;
        end
    end
endmodule

// File: rtl/mem_fill.sv
// mem_fill: parametrised RAM initialiser writing len words from start_addr (wrapping), one per cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_fill_if.slave (rdy/en request, done/err status, synchronous RAM port)
//   MEM_FILL_VERIFY_EN : when defined, a read-back pass after the fill sets err/err_addr on first mismatch
module mem_fill
    import mem_fill_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    mem_fill_if.slave  bus
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    state_e            state;
    logic [MODE_W-1:0] mode_q;
    logic [ADDR_W-1:0] start_q;
    logic [DATA_W-1:0] fill_q, step_q;
    logic [ADDR_W:0]   len_q, cnt, len_c;
    logic              accept, last, restart, advance;
    logic [DATA_W-1:0] dg_data;
    assign len_c   = bus.len > DEPTH ? DEPTH : bus.len;
    assign accept  = state == IDLE && bus.rdy && bus.en;
    assign last    = cnt == len_q - 1'b1;
    // rewinding at the end of the fill makes the verify pass regenerate the same sequence
    assign restart = accept || (state == FILL && last);
    assign advance = (state == FILL && !last) || state == VERIFY;
    assign bus.ram_din = dg_data;
    mem_fill_datagen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_datagen (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .advance (advance),
        .mode    (accept ? bus.mode : mode_q),
        .start   (accept ? bus.start_addr : start_q),
        .base    (accept ? bus.fill_val : fill_q),
        .step    (accept ? bus.step : step_q),
        .addr    (bus.ram_addr),
        .data    (dg_data)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bus.rdy      <= 1'b0;
            bus.done     <= 1'b0;
            bus.ram_wren <= 1'b0;
            cnt          <= '0;
            len_q        <= '0;
            mode_q       <= '0;
            start_q      <= '0;
            fill_q       <= '0;
            step_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.rdy <= 1'b0;
                        len_q   <= len_c;
                        cnt     <= '0;
                        mode_q  <= bus.mode;
                        start_q <= bus.start_addr;
                        fill_q  <= bus.fill_val;
                        step_q  <= bus.step;
                        if (len_c == '0) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state        <= FILL;
                            bus.ram_wren <= 1'b1;
                        end
                    end else begin
                        bus.rdy <= 1'b1;
                    end
                end
                FILL: begin
                    if (last) begin
                        bus.ram_wren <= 1'b0;
                        cnt          <= '0;
`ifdef MEM_FILL_VERIFY_EN
                        state        <= VERIFY;
`else
                        state        <= DONE;
                        bus.done     <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                VERIFY: begin
                    // len reads plus one cycle for the RAM read latency
                    if (cnt == len_q) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    bus.rdy  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef MEM_FILL_VERIFY_EN
    logic              chk_q;
    logic [DATA_W-1:0] exp_q;
    logic [ADDR_W-1:0] addr_q;
    // read data returns one cycle after the address, so expectation is delayed to match
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q        <= 1'b0;
            exp_q        <= '0;
            addr_q       <= '0;
            bus.err      <= 1'b0;
            bus.err_addr <= '0;
        end else begin
            chk_q  <= state == VERIFY && cnt != len_q;
            exp_q  <= dg_data;
            addr_q <= bus.ram_addr;
            if (accept) begin
                bus.err      <= 1'b0;
                bus.err_addr <= '0;
            end else if (chk_q && !bus.err && bus.ram_dout != exp_q) begin
                bus.err      <= 1'b1;
                bus.err_addr <= addr_q;
            end
        end
    end
`else
    logic unused_dout;
    assign unused_dout  = ^bus.ram_dout;
    assign bus.err      = 1'b0;
    assign bus.err_addr = '0;
`endif
endmodule

// File: tb/tb_mem_fill.sv
// tb_mem_fill: randomized scoreboard bench for mem_fill with a behavioural RAM and fill model.
module tb_mem_fill;
    import mem_fill_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mem_fill_if #(.ADDR_W(8), .DATA_W(8)) bus ();
    mem_fill #(.ADDR_W(8), .DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];
    int          corrupt = -1;
    int          cyc = 0;
    int          vec = 0;
    int          bad = 0;
    int          ndone = 0;
    logic [15:0] wq [$];
    int          dq [$];
    logic        exp_err = 1'b0;
    logic [7:0]  exp_eaddr = 8'h00;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i ^ 8'h5A);
        end else if (bus.ram_wren) begin
            mem[bus.ram_addr] <= int'(bus.ram_addr) == corrupt ? bus.ram_din ^ 8'h01 : bus.ram_din;
        end
        bus.ram_dout <= mem[bus.ram_addr];
    end
    function automatic void chk(input string name, input int act, input int exp);
        vec++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endfunction
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (bus.ram_wren) begin
                chk("write_expected", int'(wq.size() > 0), 1);
                if (wq.size() > 0) begin
                    logic [15:0] e;
                    e = wq.pop_front();
                    chk("wr_addr", bus.ram_addr, e[15:8]);
                    chk("wr_data", bus.ram_din, e[7:0]);
                    ref_mem[e[15:8]] = int'(e[15:8]) == corrupt ? e[7:0] ^ 8'h01 : e[7:0];
                end
            end
            if (bus.done) begin
                ndone++;
                chk("done_expected", int'(dq.size() > 0), 1);
                if (dq.size() > 0) begin
                    chk("done_cycle", cyc, dq.pop_front());
                    chk("writes_left", wq.size(), 0);
                    chk("err", bus.err, exp_err);
                    if (exp_err) chk("err_addr", bus.err_addr, exp_eaddr);
                end
            end
        end
    end
    task automatic start_op(input int m, input int s, input int l, input int f, input int st, input bit junk);
        int L;
        int a;
        int d;
        L = l > 256 ? 256 : l;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.rdy) break;
        end
        chk("rdy_wait", bus.rdy, 1);
        if (!bus.rdy) return;
        bus.mode       = 2'(m);
        bus.start_addr = 8'(s);
        bus.len        = 9'(l);
        bus.fill_val   = 8'(f);
        bus.step       = 8'(st);
        bus.en         = 1'b1;
        @(posedge clk);
        #1 bus.en = 1'b0;
        chk("rdy_drop", bus.rdy, 0);
`ifdef MEM_FILL_VERIFY_EN
        chk("err_clear", bus.err, 0);
`endif
        exp_err   = 1'b0;
        exp_eaddr = 8'h00;
        for (int i = 0; i < L; i++) begin
            a = (s + i) % 256;
            d = m == 0 ? i : m == 2 ? f + i * st : f;
            wq.push_back({8'(a), 8'(d)});
`ifdef MEM_FILL_VERIFY_EN
            if (a == corrupt && !exp_err) begin
                exp_err   = 1'b1;
                exp_eaddr = 8'(a);
            end
`endif
        end
`ifdef MEM_FILL_VERIFY_EN
        dq.push_back(L == 0 ? cyc : cyc + 2 * L + 1);
`else
        dq.push_back(cyc + L);
`endif
        if (junk && L >= 4) begin
            @(negedge clk);
            bus.en       = 1'b1;
            bus.mode     = 2'($urandom);
            bus.len      = 9'($urandom);
            bus.fill_val = 8'($urandom);
            @(negedge clk);
            bus.en = 1'b0;
        end
    endtask
    task automatic check_ram();
        int n;
        n = 0;
        for (int i = 0; i < 256; i++) if (mem[i] != ref_mem[i]) n++;
        chk("ram_contents", n, 0);
    endtask
    task automatic wait_done();
        int d0;
        d0 = ndone;
        for (int k = 0; k < 800; k++) begin
            @(posedge clk);
            if (ndone != d0) break;
        end
        chk("done_seen", ndone - d0, 1);
        @(posedge clk);
        check_ram();
    endtask
    task automatic run_op(input int m, input int s, input int l, input int f, input int st, input bit junk);
        start_op(m, s, l, f, st, junk);
        wait_done();
    endtask
    initial begin
        bus.en = 1'b0;
        bus.mode = '0;
        bus.start_addr = '0;
        bus.len = '0;
        bus.fill_val = '0;
        bus.step = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i ^ 8'h5A);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", bus.rdy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_wren", bus.ram_wren, 0);
        chk("rst_addr", bus.ram_addr, 0);
        chk("rst_din", bus.ram_din, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_err_addr", bus.err_addr, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 chk("rdy_after_rst", bus.rdy, 1);
        run_op(0, 8'h00, 256, 0, 0, 1'b1);
        run_op(1, 8'hFE, 4, 8'hA5, 0, 1'b1);
        run_op(2, 8'h00, 3, 8'hF0, 8'h20, 1'b0);
        run_op(0, 8'h33, 0, 0, 0, 1'b0);
        run_op(0, 8'h07, 300, 0, 0, 1'b1);
        run_op(3, 8'hFF, 2, 8'h6C, 8'h11, 1'b0);
        start_op(0, 8'h40, 256, 0, 0, 1'b1);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_wren", bus.ram_wren, 0);
        chk("abort_rdy", bus.rdy, 0);
        wq.delete();
        dq.delete();
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 chk("abort_rdy_back", bus.rdy, 1);
        @(posedge clk);
        check_ram();
`ifdef MEM_FILL_VERIFY_EN
        corrupt = 5;
        run_op(1, 8'h00, 16, 8'h3C, 0, 1'b0);
        corrupt = -1;
        run_op(2, 8'h00, 8, 8'h01, 8'h03, 1'b0);
`endif
        for (int n = 0; n < 25; n++) begin
            int l;
            l = $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 40));
            run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), l,
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
